router_register: RTL and testbench
==================================

# router_register

Datapath register stage of the 1x3 router, directly downstream of the router FSM. It captures the packet header, forwards header, payload and parity bytes to the output FIFOs on `dout`, and holds one byte when the destination FIFO is full. It also accumulates running parity and a payload byte count, and reports `parity_done`, `low_pkt_valid`, a parity error and a length error back to the FSM and to the top level.

## Interface
- WIDTH, 8, data byte width; minimum 8.
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  synchronous, active-low reset.
- pkt_valid  in  1  source asserts for header and payload bytes; deasserts on the parity byte.
- data_in  in  WIDTH  packet byte; [1:0] is the address, [7:2] is the payload length.
- fifo_full  in  1  selected destination FIFO is full.
- detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  in  1 each  one-hot state decodes from the FSM.
- dout  out  WIDTH  byte to the FIFO write port.
- parity_done  out  1  parity byte has been captured.
- low_pkt_valid  out  1  pkt_valid fell while in LOAD_DATA.
- err  out  1  parity mismatch for the last packet.
- len_err  out  1  payload count ≠ header length field.

## Operation
Reset applies to all outputs and internal registers: `dout`, `parity_done`, `low_pkt_valid`, `err`, `len_err` and the internals below all reset to 0.

Internal registers:
- header_byte
- full_byte
- int_parity
- pkt_parity
- pay_cnt (6-bit, wraps at 63→0)

Per-register behaviour, priority top-down:
- **header_byte**
  - If detect_add & pkt_valid & data_in[1:0]≠2'b11: load data_in.
  - Otherwise hold.
- **dout**
  - lfd_state: dout ← header_byte.
  - ld_state & !fifo_full: dout ← data_in.
  - laf_state: dout ← full_byte.
  - Otherwise hold.
- **full_byte**
  - ld_state & fifo_full: full_byte ← data_in. This byte is not lost.
- **low_pkt_valid**
  - rst_int_reg: clear to 0.
  - ld_state & !pkt_valid: set to 1.
  - Otherwise hold.
- **parity_done**
  - detect_add: clear to 0.
  - (ld_state & !fifo_full & !pkt_valid) or (laf_state & low_pkt_valid & !parity_done): set to 1.
  - Otherwise hold.
- **pkt_parity**
  - detect_add: clear to 0.
  - Under the same two conditions that set parity_done: pkt_parity ← data_in.
- **int_parity**
  - detect_add: clear to 0.
  - lfd_state: int_parity ^= header_byte.
  - ld_state & pkt_valid & !full_state: int_parity ^= data_in. This includes the byte diverted into full_byte.
- **pay_cnt**
  - detect_add: clear to 0.
  - Increments under exactly the condition that XORs data_in into int_parity.
- **err / len_err**
  - detect_add: clear both to 0.
  - Else if parity_done: err ← (int_parity ≠ pkt_parity) and len_err ← (pay_cnt ≠ header_byte[7:2]).
  - Otherwise hold.
  - Both stay valid until the next detect_add.

Boundary conditions:
- Address 2'b11 in DECODE_ADDRESS: header_byte is not loaded and the previous value is kept.
- Length field 0 (header then parity only): pay_cnt = 0, len_err = 0.
- fifo_full on the parity byte in LOAD_DATA: the parity byte goes to full_byte. parity_done and pkt_parity are set later in laf_state.
- Reset mid-packet returns every register to 0 on the next edge. This takes priority over all other conditions.

## Timing
- Header: latched on the edge ending DECODE_ADDRESS, and appears on dout one edge after LOAD_FIRST_DATA.
- Payload: each payload byte appears on dout one cycle after it is presented in LOAD_DATA (1-cycle latency).
- parity_done: high on the edge ending the last LOAD_DATA cycle, i.e. it is high during LOAD_PARITY.
- err / len_err: update on the edge ending LOAD_PARITY and are valid during CHECK_PARITY_ERROR.
- Full-FIFO hold: the byte presented when fifo_full is high is emitted on dout one cycle after the laf_state cycle. No byte is duplicated or dropped.

## Test plan
- **Clean packet.** Reset → drive header 8'h0D (address 1, length 3), payload 11, 22, 33, parity 8'h0D with the FSM-state sequence.
  - Required: dout sequence 0D, 11, 22, 33, 0D.
  - Required: parity_done = 1 during LOAD_PARITY, err = 0, len_err = 0.
- **Bad parity.** Same packet with parity 8'h0E.
  - Required: err = 1 during CHECK_PARITY_ERROR, held until the next detect_add.
- **Length mismatch.** Header 8'h11 (length 4), 3 payload bytes 11, 22, 33, correct parity.
  - Required: err = 0, len_err = 1.
- **FIFO full mid-payload.** fifo_full = 1 while 22 is presented, then FULL_STATE → LAF → LOAD_DATA.
  - Required: 22 is held in full_byte and appears on dout after laf_state.
  - Required: the full output stream is 0D, 11, 22, 33, 0D and err = 0.
- **Full on the parity byte.** fifo_full = 1 on the parity byte, then laf_state with low_pkt_valid = 1.
  - Required: parity_done rises after laf_state, pkt_parity = 0D, err = 0.
- **Reset mid-packet.** Assert resetn = 0 after byte 11.
  - Required: all outputs are 0 on the next edge.
  - Required: the next clean packet passes with err = 0 and len_err = 0.

Source files
------------

// File: rtl/router_register.sv
// Datapath register stage of the 1x3 router: header capture, byte forwarding, full-FIFO
// holding byte, running parity and payload count with parity/length error reporting.
module router_register #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_pkt_valid,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic             i_fifo_full,
    input  logic             i_detect_add,
    input  logic             i_lfd_state,
    input  logic             i_ld_state,
    input  logic             i_laf_state,
    input  logic             i_full_state,
    input  logic             i_rst_int_reg,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_parity_done,
    output logic             o_low_pkt_valid,
    output logic             o_err,
    output logic             o_len_err
);

    logic [WIDTH-1:0] r_header_byte;
    logic [WIDTH-1:0] r_full_byte;
    logic [WIDTH-1:0] r_int_parity;
    logic [WIDTH-1:0] r_pkt_parity;
    logic [5:0]       r_pay_cnt;
    logic [WIDTH-1:0] r_dout;
    logic             r_parity_done;
    logic             r_low_pkt_valid;
    logic             r_err;
    logic             r_len_err;

    logic [WIDTH-1:0] w_header_nxt;
    logic [WIDTH-1:0] w_full_nxt;
    logic [WIDTH-1:0] w_int_parity_nxt;
    logic [WIDTH-1:0] w_pkt_parity_nxt;
    logic [5:0]       w_pay_cnt_nxt;
    logic [WIDTH-1:0] w_dout_nxt;
    logic             w_parity_done_nxt;
    logic             w_low_pkt_valid_nxt;
    logic             w_err_nxt;
    logic             w_len_err_nxt;

    logic             w_par_set;
    logic             w_acc;

    // Parity byte is taken either directly in LOAD_DATA or, if the FIFO was full, from LAF.
    assign w_par_set = (i_ld_state && !i_fifo_full && !i_pkt_valid) ||
                       (i_laf_state && r_low_pkt_valid && !r_parity_done);
    // Diverted bytes still count: fifo_full is deliberately absent here.
    assign w_acc     = i_ld_state && i_pkt_valid && !i_full_state;

    always_comb begin
        w_header_nxt        = r_header_byte;
        w_full_nxt          = r_full_byte;
        w_int_parity_nxt    = r_int_parity;
        w_pkt_parity_nxt    = r_pkt_parity;
        w_pay_cnt_nxt       = r_pay_cnt;
        w_dout_nxt          = r_dout;
        w_parity_done_nxt   = r_parity_done;
        w_low_pkt_valid_nxt = r_low_pkt_valid;
        w_err_nxt           = r_err;
        w_len_err_nxt       = r_len_err;

        if (i_detect_add && i_pkt_valid && (i_data_in[1:0] != 2'b11)) begin
            w_header_nxt = i_data_in;
        end

        if (i_lfd_state) begin
            w_dout_nxt = r_header_byte;
        end else if (i_ld_state && !i_fifo_full) begin
            w_dout_nxt = i_data_in;
        end else if (i_laf_state) begin
            w_dout_nxt = r_full_byte;
        end

        if (i_ld_state && i_fifo_full) begin
            w_full_nxt = i_data_in;
        end

        if (i_rst_int_reg) begin
            w_low_pkt_valid_nxt = 1'b0;
        end else if (i_ld_state && !i_pkt_valid) begin
            w_low_pkt_valid_nxt = 1'b1;
        end

        if (i_detect_add) begin
            w_parity_done_nxt = 1'b0;
            w_pkt_parity_nxt  = '0;
            w_int_parity_nxt  = '0;
            w_pay_cnt_nxt     = '0;
            w_err_nxt         = 1'b0;
            w_len_err_nxt     = 1'b0;
        end else begin
            if (w_par_set) begin
                w_parity_done_nxt = 1'b1;
                w_pkt_parity_nxt  = i_data_in;
            end
            if (i_lfd_state) begin
                w_int_parity_nxt = r_int_parity ^ r_header_byte;
            end else if (w_acc) begin
                w_int_parity_nxt = r_int_parity ^ i_data_in;
            end
            if (w_acc) begin
                w_pay_cnt_nxt = r_pay_cnt + 6'd1;
            end
            if (r_parity_done) begin
                w_err_nxt     = (r_int_parity != r_pkt_parity);
                w_len_err_nxt = (r_pay_cnt != r_header_byte[7:2]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_header_byte   <= '0;
            r_full_byte     <= '0;
            r_int_parity    <= '0;
            r_pkt_parity    <= '0;
            r_pay_cnt       <= '0;
            r_dout          <= '0;
            r_parity_done   <= 1'b0;
            r_low_pkt_valid <= 1'b0;
            r_err           <= 1'b0;
            r_len_err       <= 1'b0;
        end else begin
            r_header_byte   <= w_header_nxt;
            r_full_byte     <= w_full_nxt;
            r_int_parity    <= w_int_parity_nxt;
            r_pkt_parity    <= w_pkt_parity_nxt;
            r_pay_cnt       <= w_pay_cnt_nxt;
            r_dout          <= w_dout_nxt;
            r_parity_done   <= w_parity_done_nxt;
            r_low_pkt_valid <= w_low_pkt_valid_nxt;
            r_err           <= w_err_nxt;
            r_len_err       <= w_len_err_nxt;
        end
    end

    assign o_dout          = r_dout;
    assign o_parity_done   = r_parity_done;
    assign o_low_pkt_valid = r_low_pkt_valid;
    assign o_err           = r_err;
    assign o_len_err       = r_len_err;

endmodule

// File: tb/tb_router_register.sv
// Directed bench for router_register: drives FSM state decodes cycle by cycle and
// compares outputs against hand-computed values.
module tb_router_register;

    logic       clk;
    logic       resetn;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic [7:0] dout;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       err;
    logic       len_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] pay [4];
    logic [7:0] got [6];
    logic       pd_lp, lpv_lp, err_cpe, len_cpe;

    router_register #(.WIDTH(8)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .i_pkt_valid    (pkt_valid),
        .i_data_in      (data_in),
        .i_fifo_full    (fifo_full),
        .i_detect_add   (detect_add),
        .i_lfd_state    (lfd_state),
        .i_ld_state     (ld_state),
        .i_laf_state    (laf_state),
        .i_full_state   (full_state),
        .i_rst_int_reg  (rst_int_reg),
        .o_dout         (dout),
        .o_parity_done  (parity_done),
        .o_low_pkt_valid(low_pkt_valid),
        .o_err          (err),
        .o_len_err      (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clr();
        pkt_valid = 0; data_in = 8'h00; fifo_full = 0; detect_add = 0; lfd_state = 0;
        ld_state = 0; laf_state = 0; full_state = 0; rst_int_reg = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic st_decode(input logic [7:0] h);
        clr(); detect_add = 1; pkt_valid = 1; data_in = h; step();
    endtask

    task automatic st_lfd();
        clr(); lfd_state = 1; pkt_valid = 1; data_in = 8'hA5; step();
    endtask

    task automatic st_ld(input logic pv, input logic [7:0] d, input logic ff);
        clr(); ld_state = 1; pkt_valid = pv; data_in = d; fifo_full = ff; step();
    endtask

    task automatic st_full(input logic pv, input logic [7:0] d);
        clr(); full_state = 1; pkt_valid = pv; data_in = d; step();
    endtask

    task automatic st_laf(input logic pv, input logic [7:0] d);
        clr(); laf_state = 1; pkt_valid = pv; data_in = d; step();
    endtask

    task automatic st_lp();
        clr(); step();
    endtask

    task automatic st_cpe();
        clr(); rst_int_reg = 1; step();
    endtask

    task automatic run_packet(input logic [7:0] hdr, input int n, input logic [7:0] par);
        st_decode(hdr);
        st_lfd();
        got[0] = dout;
        for (int i = 0; i < n; i++) begin
            st_ld(1'b1, pay[i], 1'b0);
            got[i+1] = dout;
        end
        st_ld(1'b0, par, 1'b0);
        got[n+1] = dout;
        pd_lp  = parity_done;
        lpv_lp = low_pkt_valid;
        st_lp();
        err_cpe = err;
        len_cpe = len_err;
        st_cpe();
    endtask

    task automatic test_reset();
        resetn = 0;
        clr();
        step(); step();
        n_checks++; if (dout !== 8'h00) begin
            n_errors++; $display("FAIL reset dout: got %h want 00", dout); end
        n_checks++; if (parity_done !== 1'b0) begin
            n_errors++; $display("FAIL reset parity_done: got %b want 0", parity_done); end
        n_checks++; if (low_pkt_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset low_pkt_valid: got %b want 0", low_pkt_valid); end
        n_checks++; if (err !== 1'b0) begin
            n_errors++; $display("FAIL reset err: got %b want 0", err); end
        n_checks++; if (len_err !== 1'b0) begin
            n_errors++; $display("FAIL reset len_err: got %b want 0", len_err); end
        resetn = 1;
        step();
    endtask

    task automatic test_clean_packet();
        logic [7:0] exp [5];
        exp = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        run_packet(8'h0D, 3, 8'h0D);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (got[i] !== exp[i]) begin
                n_errors++; $display("FAIL clean dout[%0d]: got %h want %h", i, got[i], exp[i]);
            end
        end
        n_checks++; if (pd_lp !== 1'b1) begin
            n_errors++; $display("FAIL clean parity_done in LP: got %b want 1", pd_lp); end
        n_checks++; if (lpv_lp !== 1'b1) begin
            n_errors++; $display("FAIL clean low_pkt_valid in LP: got %b want 1", lpv_lp); end
        n_checks++; if (err_cpe !== 1'b0) begin
            n_errors++; $display("FAIL clean err: got %b want 0", err_cpe); end
        n_checks++; if (len_cpe !== 1'b0) begin
            n_errors++; $display("FAIL clean len_err: got %b want 0", len_cpe); end
        n_checks++; if (low_pkt_valid !== 1'b0) begin
            n_errors++; $display("FAIL clean low_pkt_valid after rst_int_reg: got %b want 0",
                                 low_pkt_valid); end
    endtask

    task automatic test_bad_parity();
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        run_packet(8'h0D, 3, 8'h0E);
        n_checks++; if (err_cpe !== 1'b1) begin
            n_errors++; $display("FAIL badpar err: got %b want 1", err_cpe); end
        n_checks++; if (len_cpe !== 1'b0) begin
            n_errors++; $display("FAIL badpar len_err: got %b want 0", len_cpe); end
        st_lp(); st_lp();
        n_checks++; if (err !== 1'b1) begin
            n_errors++; $display("FAIL badpar err held: got %b want 1", err); end
        st_decode(8'h0D);
        n_checks++; if (err !== 1'b0) begin
            n_errors++; $display("FAIL badpar err after detect_add: got %b want 0", err); end
        n_checks++; if (parity_done !== 1'b0) begin
            n_errors++; $display("FAIL badpar parity_done after detect_add: got %b want 0",
                                 parity_done); end
    endtask

    task automatic test_len_mismatch();
        logic [7:0] exp [5];
        exp = '{8'h11, 8'h11, 8'h22, 8'h33, 8'h11};
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        run_packet(8'h11, 3, 8'h11);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (got[i] !== exp[i]) begin
                n_errors++; $display("FAIL lenmis dout[%0d]: got %h want %h", i, got[i], exp[i]);
            end
        end
        n_checks++; if (err_cpe !== 1'b0) begin
            n_errors++; $display("FAIL lenmis err: got %b want 0", err_cpe); end
        n_checks++; if (len_cpe !== 1'b1) begin
            n_errors++; $display("FAIL lenmis len_err: got %b want 1", len_cpe); end
    endtask

    task automatic test_fifo_full_payload();
        logic [7:0] exp [5];
        exp = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        st_decode(8'h0D);
        st_lfd();                   got[0] = dout;
        st_ld(1'b1, 8'h11, 1'b0);   got[1] = dout;
        st_ld(1'b1, 8'h22, 1'b1);
        n_checks++; if (dout !== 8'h11) begin
            n_errors++; $display("FAIL ffpay dout hold on full: got %h want 11", dout); end
        st_full(1'b1, 8'h33);
        n_checks++; if (dout !== 8'h11) begin
            n_errors++; $display("FAIL ffpay dout hold in FULL: got %h want 11", dout); end
        st_laf(1'b1, 8'h33);        got[2] = dout;
        st_ld(1'b1, 8'h33, 1'b0);   got[3] = dout;
        st_ld(1'b0, 8'h0D, 1'b0);   got[4] = dout;
        st_lp();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (got[i] !== exp[i]) begin
                n_errors++; $display("FAIL ffpay dout[%0d]: got %h want %h", i, got[i], exp[i]);
            end
        end
        n_checks++; if (err !== 1'b0) begin
            n_errors++; $display("FAIL ffpay err: got %b want 0", err); end
        n_checks++; if (len_err !== 1'b0) begin
            n_errors++; $display("FAIL ffpay len_err: got %b want 0", len_err); end
        st_cpe();
    endtask

    task automatic test_full_on_parity();
        st_decode(8'h0D);
        st_lfd();
        st_ld(1'b1, 8'h11, 1'b0);
        st_ld(1'b1, 8'h22, 1'b0);
        st_ld(1'b1, 8'h33, 1'b0);
        st_ld(1'b0, 8'h0D, 1'b1);
        n_checks++; if (parity_done !== 1'b0) begin
            n_errors++; $display("FAIL ffpar parity_done on full: got %b want 0", parity_done); end
        n_checks++; if (low_pkt_valid !== 1'b1) begin
            n_errors++; $display("FAIL ffpar low_pkt_valid: got %b want 1", low_pkt_valid); end
        n_checks++; if (dout !== 8'h33) begin
            n_errors++; $display("FAIL ffpar dout hold: got %h want 33", dout); end
        st_full(1'b0, 8'h0D);
        n_checks++; if (parity_done !== 1'b0) begin
            n_errors++; $display("FAIL ffpar parity_done in FULL: got %b want 0", parity_done); end
        st_laf(1'b0, 8'h0D);
        n_checks++; if (parity_done !== 1'b1) begin
            n_errors++; $display("FAIL ffpar parity_done after LAF: got %b want 1", parity_done); end
        n_checks++; if (dout !== 8'h0D) begin
            n_errors++; $display("FAIL ffpar dout after LAF: got %h want 0d", dout); end
        st_lp();
        n_checks++; if (err !== 1'b0) begin
            n_errors++; $display("FAIL ffpar err: got %b want 0", err); end
        n_checks++; if (len_err !== 1'b0) begin
            n_errors++; $display("FAIL ffpar len_err: got %b want 0", len_err); end
        st_cpe();
    endtask

    task automatic test_len_zero();
        run_packet(8'h02, 0, 8'h02);
        n_checks++; if (got[0] !== 8'h02) begin
            n_errors++; $display("FAIL len0 header dout: got %h want 02", got[0]); end
        n_checks++; if (got[1] !== 8'h02) begin
            n_errors++; $display("FAIL len0 parity dout: got %h want 02", got[1]); end
        n_checks++; if (pd_lp !== 1'b1) begin
            n_errors++; $display("FAIL len0 parity_done: got %b want 1", pd_lp); end
        n_checks++; if (err_cpe !== 1'b0) begin
            n_errors++; $display("FAIL len0 err: got %b want 0", err_cpe); end
        n_checks++; if (len_cpe !== 1'b0) begin
            n_errors++; $display("FAIL len0 len_err: got %b want 0", len_cpe); end
    endtask

    // Header register still holds 8'h02 from the previous packet.
    task automatic test_bad_addr();
        run_packet(8'hFF, 0, 8'h02);
        n_checks++; if (got[0] !== 8'h02) begin
            n_errors++; $display("FAIL badaddr header kept: got %h want 02", got[0]); end
        n_checks++; if (err_cpe !== 1'b0) begin
            n_errors++; $display("FAIL badaddr err: got %b want 0", err_cpe); end
        n_checks++; if (len_cpe !== 1'b0) begin
            n_errors++; $display("FAIL badaddr len_err: got %b want 0", len_cpe); end
    endtask

    task automatic test_reset_mid_packet();
        logic [7:0] exp [5];
        exp = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        // Leave err and parity_done high, then reset without any detect_add.
        run_packet(8'h0D, 3, 8'h0E);
        clr(); resetn = 0; step();
        n_checks++; if (err !== 1'b0) begin
            n_errors++; $display("FAIL rstmid err after held: got %b want 0", err); end
        n_checks++; if (parity_done !== 1'b0) begin
            n_errors++; $display("FAIL rstmid parity_done after held: got %b want 0", parity_done);
        end
        resetn = 1;
        st_decode(8'h0D);
        st_lfd();
        st_ld(1'b1, 8'h11, 1'b0);
        clr(); ld_state = 1; pkt_valid = 0; data_in = 8'h22; resetn = 0; step();
        n_checks++; if (dout !== 8'h00) begin
            n_errors++; $display("FAIL rstmid dout: got %h want 00", dout); end
        n_checks++; if (parity_done !== 1'b0) begin
            n_errors++; $display("FAIL rstmid parity_done: got %b want 0", parity_done); end
        n_checks++; if (low_pkt_valid !== 1'b0) begin
            n_errors++; $display("FAIL rstmid low_pkt_valid: got %b want 0", low_pkt_valid); end
        n_checks++; if (err !== 1'b0 || len_err !== 1'b0) begin
            n_errors++; $display("FAIL rstmid err/len_err: got %b%b want 00", err, len_err); end
        resetn = 1;
        clr(); step();
        run_packet(8'h0D, 3, 8'h0D);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (got[i] !== exp[i]) begin
                n_errors++; $display("FAIL rstmid next dout[%0d]: got %h want %h",
                                     i, got[i], exp[i]);
            end
        end
        n_checks++; if (err_cpe !== 1'b0) begin
            n_errors++; $display("FAIL rstmid next err: got %b want 0", err_cpe); end
        n_checks++; if (len_cpe !== 1'b0) begin
            n_errors++; $display("FAIL rstmid next len_err: got %b want 0", len_cpe); end
    endtask

    initial begin
        test_reset();
        test_clean_packet();
        test_bad_parity();
        test_len_mismatch();
        test_fifo_full_payload();
        test_full_on_parity();
        test_len_zero();
        test_bad_addr();
        test_reset_mid_packet();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
